prog_clock_divider: RTL and testbench



---
 rtl/clk_div_pkg.sv | 14 +
 rtl/clk_div_channel.sv | 94 +++++++++
 rtl/prog_clock_divider.sv | 44 ++++
 tb/tb_prog_clock_divider.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared divisor constants for a 100 MHz board clock and the channel-select width helper.
package clk_div_pkg;

    // A divisor D gives one tick every D+1 cycles; sq runs at half the tick rate.
    localparam int unsigned DIV_1HZ   = 49_999_999;
    localparam int unsigned DIV_2HZ   = 24_999_999;
    localparam int unsigned DIV_10HZ  = 4_999_999;
    localparam int unsigned DIV_1KHZ  = 49_999;

    function automatic int unsigned ch_w(input int unsigned num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, live divisor, shadow divisor and registered sq/tick outputs.
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W       = 27,
    parameter int unsigned DEFAULT_DIV = DIV_1HZ
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] div_i,
    output logic             sq_o,
    output logic             tick_o,
    output logic             pending_o
);

    localparam logic [CNT_W-1:0] DefDiv = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             sq_q, sq_d;
    logic             tick_q, tick_d;
    logic             pend_q, pend_d;
    logic             tc;

    // Terminal count only exists on an enabled, non-cleared edge.
    assign tc = en_i && !clr_i && (cnt_q == div_q);

    always_comb begin
        cnt_d    = cnt_q;
        sq_d     = sq_q;
        tick_d   = 1'b0;
        div_d    = div_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;

        if (clr_i) begin
            cnt_d = '0;
            sq_d  = 1'b0;
        end else if (en_i) begin
            if (tc) begin
                cnt_d  = '0;
                sq_d   = ~sq_q;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // Divisor changes only land on a period boundary or while the channel is stopped.
        if (wr_i) begin
            shadow_d = div_i;
            if (!en_i) begin
                div_d  = div_i;
                cnt_d  = '0;
                pend_d = 1'b0;
            end else if (tc) begin
                div_d  = div_i;
                pend_d = 1'b0;
            end else begin
                pend_d = 1'b1;
            end
        end else if (tc && pend_q) begin
            div_d  = shadow_q;
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            div_q    <= DefDiv;
            shadow_q <= DefDiv;
            sq_q     <= 1'b0;
            tick_q   <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            shadow_q <= shadow_d;
            sq_q     <= sq_d;
            tick_q   <= tick_d;
            pend_q   <= pend_d;
        end
    end

    assign sq_o      = sq_q;
    assign tick_o    = tick_q;
    assign pending_o = pend_q;

endmodule

// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider: decodes divisor writes and replicates the channel.
module prog_clock_divider
    import clk_div_pkg::*;
#(
    parameter  int unsigned NUM_CH      = 4,
    parameter  int unsigned CNT_W       = 27,
    parameter  int unsigned DEFAULT_DIV = DIV_1HZ,
    localparam int unsigned CH_W        = ch_w(NUM_CH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NUM_CH-1:0] en_i,
    input  logic              sync_clr_i,
    input  logic              cfg_wr_i,
    input  logic [CH_W-1:0]   cfg_ch_i,
    input  logic [CNT_W-1:0]  cfg_div_i,
    output logic [NUM_CH-1:0] sq_o,
    output logic [NUM_CH-1:0] tick_o,
    output logic [NUM_CH-1:0] pending_o
);

    logic [NUM_CH-1:0] wr_sel;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Selects at or beyond NUM_CH match no channel, so those writes are dropped.
        assign wr_sel[i] = cfg_wr_i && (cfg_ch_i == CH_W'(i));

        clk_div_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .en_i      (en_i[i]),
            .clr_i     (sync_clr_i),
            .wr_i      (wr_sel[i]),
            .div_i     (cfg_div_i),
            .sq_o      (sq_o[i]),
            .tick_o    (tick_o[i]),
            .pending_o (pending_o[i])
        );
    end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Scoreboard bench: directed cycles push hand-derived expectations, a negedge monitor checks them.
module tb_prog_clock_divider;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic [1:0] en = 2'b00;
    logic       sync_clr = 1'b0;
    logic       cfg_wr = 1'b0;
    logic       cfg_ch = 1'b0;
    logic [7:0] cfg_div = 8'd0;
    logic [1:0] sq, tick, pending;

    // Second instance with three channels so an out-of-range select is representable.
    logic [2:0] en3 = 3'b111;
    logic       clr3 = 1'b0;
    logic       wr3 = 1'b0;
    logic [1:0] ch3 = 2'd3;
    logic [7:0] div3 = 8'd0;
    logic [2:0] sq3, tick3, pend3;

    prog_clock_divider #(.NUM_CH(2), .CNT_W(8), .DEFAULT_DIV(3)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .en_i      (en),
        .sync_clr_i(sync_clr),
        .cfg_wr_i  (cfg_wr),
        .cfg_ch_i  (cfg_ch),
        .cfg_div_i (cfg_div),
        .sq_o      (sq),
        .tick_o    (tick),
        .pending_o (pending)
    );

    prog_clock_divider #(.NUM_CH(3), .CNT_W(8), .DEFAULT_DIV(3)) dut3 (
        .clk_i     (clk),
        .rst_i     (rst),
        .en_i      (en3),
        .sync_clr_i(clr3),
        .cfg_wr_i  (wr3),
        .cfg_ch_i  (ch3),
        .cfg_div_i (div3),
        .sq_o      (sq3),
        .tick_o    (tick3),
        .pending_o (pend3)
    );

    logic [14:0] exp_q[$];
    string       name_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          k3 = 0;
    logic [14:0] mon_exp, mon_act;
    string       mon_name;

    // One clock: drive inputs, take the edge, push expectation for the outputs after it.
    task automatic cyc(input logic r, input logic [1:0] e, input logic c, input logic w,
                       input logic ch, input logic [7:0] d, input logic [1:0] xsq,
                       input logic [1:0] xt, input logic [1:0] xp, input string nm);
        logic [2:0] s3, t3;
        rst = r; en = e; sync_clr = c; cfg_wr = w; cfg_ch = ch; cfg_div = d;
        @(posedge clk);
        k3 = r ? 0 : k3 + 1;
        t3 = (k3 != 0 && k3 % 4 == 0) ? 3'b111 : 3'b000;
        s3 = ((k3 / 4) % 2 == 1) ? 3'b111 : 3'b000;
        exp_q.push_back({xsq, xt, xp, s3, t3, 3'b000});
        name_q.push_back(nm);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            mon_act  = {sq, tick, pending, sq3, tick3, pend3};
            n_cmp++;
            if (mon_act !== mon_exp) begin
                n_fail++;
                $display("FAIL %s @%0t: got sq=%b tick=%b pend=%b sq3=%b tick3=%b pend3=%b, want sq=%b tick=%b pend=%b sq3=%b tick3=%b pend3=%b",
                         mon_name, $time, mon_act[14:13], mon_act[12:11], mon_act[10:9],
                         mon_act[8:6], mon_act[5:3], mon_act[2:0], mon_exp[14:13],
                         mon_exp[12:11], mon_exp[10:9], mon_exp[8:6], mon_exp[5:3],
                         mon_exp[2:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset
        cyc(1, 2'b00, 0, 0, 0, 8'd0, 2'b00, 2'b00, 2'b00, "reset0");
        cyc(1, 2'b00, 0, 0, 0, 8'd0, 2'b00, 2'b00, 2'b00, "reset1");
        // run from reset, mid-run write of divisor 1 to channel 0
        cyc(0, 2'b11, 0, 0, 0, 8'd0, 2'b00, 2'b00, 2'b00, "run1");
        cyc(0, 2'b11, 0, 0, 0, 8'd0, 2'b00, 2'b00, 2'b00, "run2");
        cyc(0, 2'b11, 0, 0, 0, 8'd0, 2'b00, 2'b00, 2'b00, "run3");
        cyc(0, 2'b11, 0, 0, 0, 8'd0, 2'b11, 2'b11, 2'b00, "first_tick");
        cyc(0, 2'b11, 0, 0, 0, 8'd0, 2'b11, 2'b00, 2'b00, "run5");
        wr3 = 1'b1;
        cyc(0, 2'b11, 0, 1, 0, 8'd1, 2'b11, 2'b00, 2'b01, "wr_mid_pending");
        wr3 = 1'b0;
        cyc(0, 2'b11, 0, 0, 0, 8'd0, 2'b11, 2'b00, 2'b01, "still_pending");
        cyc(0, 2'b11, 0, 0, 0, 8'd0, 2'b00, 2'b11, 2'b00, "apply_at_tc");
        cyc(0, 2'b11, 0, 0, 0, 8'd0, 2'b00, 2'b00, 2'b00, "run9");
        cyc(0, 2'b11, 0, 0, 0, 8'd0, 2'b01, 2'b01, 2'b00, "div1_tick");
        cyc(0, 2'b11, 0, 0, 0, 8'd0, 2'b01, 2'b00, 2'b00, "run11");
        cyc(0, 2'b11, 0, 0, 0, 8'd0, 2'b10, 2'b11, 2'b00, "run12");
        // write divisor 0 exactly on a terminal count
        cyc(0, 2'b11, 0, 0, 0, 8'd0, 2'b10, 2'b00, 2'b00, "run13");
        cyc(0, 2'b11, 0, 1, 0, 8'd0, 2'b11, 2'b01, 2'b00, "wr_at_tc");
        cyc(0, 2'b11, 0, 0, 0, 8'd0, 2'b10, 2'b01, 2'b00, "div0_a");
        cyc(0, 2'b11, 0, 0, 0, 8'd0, 2'b01, 2'b11, 2'b00, "div0_b");
        // pause channel 1 at count 2 for five cycles
        cyc(0, 2'b11, 0, 0, 0, 8'd0, 2'b00, 2'b01, 2'b00, "run17");
        cyc(0, 2'b11, 0, 0, 0, 8'd0, 2'b01, 2'b01, 2'b00, "run18");
        for (int i = 19; i <= 23; i++) begin
            cyc(0, 2'b01, 0, 0, 0, 8'd0, (i % 2 == 0) ? 2'b01 : 2'b00, 2'b01, 2'b00, "en1_hold");
        end
        cyc(0, 2'b11, 0, 0, 0, 8'd0, 2'b01, 2'b01, 2'b00, "resume1");
        cyc(0, 2'b11, 0, 0, 0, 8'd0, 2'b10, 2'b11, 2'b00, "resume_tick");
        cyc(0, 2'b11, 0, 0, 0, 8'd0, 2'b11, 2'b01, 2'b00, "run26");
        // sync clear together with a write to channel 0
        cyc(0, 2'b11, 1, 1, 0, 8'd3, 2'b00, 2'b00, 2'b01, "clr_and_wr");
        cyc(0, 2'b11, 0, 0, 0, 8'd0, 2'b01, 2'b01, 2'b00, "post_clr1");
        cyc(0, 2'b11, 0, 0, 0, 8'd0, 2'b01, 2'b00, 2'b00, "post_clr2");
        cyc(0, 2'b11, 0, 0, 0, 8'd0, 2'b01, 2'b00, 2'b00, "post_clr3");
        cyc(0, 2'b11, 0, 0, 0, 8'd0, 2'b11, 2'b10, 2'b00, "post_clr4_tick");
        cyc(0, 2'b11, 0, 0, 0, 8'd0, 2'b10, 2'b01, 2'b00, "post_clr5");
        // write to channel 1 while disabled takes effect immediately
        cyc(0, 2'b01, 0, 0, 0, 8'd0, 2'b10, 2'b00, 2'b00, "dis1");
        cyc(0, 2'b01, 0, 1, 1, 8'd1, 2'b10, 2'b00, 2'b00, "wr_disabled");
        cyc(0, 2'b11, 0, 0, 0, 8'd0, 2'b10, 2'b00, 2'b00, "run35");
        cyc(0, 2'b11, 0, 0, 0, 8'd0, 2'b01, 2'b11, 2'b00, "run36");
        // two writes while pending: last one wins
        cyc(0, 2'b11, 0, 1, 0, 8'd5, 2'b01, 2'b00, 2'b01, "wr_first");
        cyc(0, 2'b11, 0, 1, 0, 8'd2, 2'b11, 2'b10, 2'b01, "wr_second");
        cyc(0, 2'b11, 0, 0, 0, 8'd0, 2'b11, 2'b00, 2'b01, "run39");
        cyc(0, 2'b11, 0, 0, 0, 8'd0, 2'b00, 2'b11, 2'b00, "apply_last");
        cyc(0, 2'b11, 0, 0, 0, 8'd0, 2'b00, 2'b00, 2'b00, "run41");
        cyc(0, 2'b11, 0, 0, 0, 8'd0, 2'b10, 2'b10, 2'b00, "run42");
        cyc(0, 2'b11, 0, 0, 0, 8'd0, 2'b11, 2'b01, 2'b00, "div2_tick");
        // reset with channel 0 pending and sq high
        cyc(0, 2'b11, 0, 1, 0, 8'd7, 2'b01, 2'b10, 2'b01, "wr_before_rst");
        cyc(1, 2'b11, 0, 0, 0, 8'd0, 2'b00, 2'b00, 2'b00, "mid_reset");
        cyc(0, 2'b11, 0, 0, 0, 8'd0, 2'b00, 2'b00, 2'b00, "rerun1");
        cyc(0, 2'b11, 0, 0, 0, 8'd0, 2'b00, 2'b00, 2'b00, "rerun2");
        cyc(0, 2'b11, 0, 0, 0, 8'd0, 2'b00, 2'b00, 2'b00, "rerun3");
        cyc(0, 2'b11, 0, 0, 0, 8'd0, 2'b11, 2'b11, 2'b00, "rerun_default_div");
        cyc(0, 2'b11, 0, 0, 0, 8'd0, 2'b11, 2'b00, 2'b00, "rerun5");

        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
